robot_path_scheduler: RTL and testbench
=======================================

Name: robot_path_scheduler

Overview:
- Autonomous move sequencer for the robot sprite on the 10x5 board grid.
- On a Go request it steps the robot one cell at a time toward a target cell, paced by video frames.
- It avoids stepping into the black-cell obstacle and marks trash sprites collected when the robot lands on them.
- Its RobotCol/RobotRow outputs feed the sprite position packing in place of direct gamepad placement.

Parameters:
- FRAMES_PER_STEP, 4, frames between successive robot steps (1..63).
- NUM_COLS, 10, highest legal column (columns are 1..NUM_COLS).
- NUM_ROWS, 5, highest legal row (rows are 1..NUM_ROWS).
- START_COL, 1, robot column after reset.
- START_ROW, 5, robot row after reset.

Ports:
- Clock50  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- v_sync  in  1  VGA vertical sync, asynchronous to the logic.
- Go  in  1  move request; sampled only in IDLE.
- TargetCol  in  4  destination column.
- TargetRow  in  3  destination row.
- ObstCol  in  4  black-cell column.
- ObstRow  in  3  black-cell row.
- TrashCols  in  12  {trash2, trash1, trash0} columns, 4 bits each.
- TrashRows  in  9  {trash2, trash1, trash0} rows, 3 bits each.
- ClearTrash  in  1  clears all collected flags.
- RobotCol  out  4  current robot column.
- RobotRow  out  3  current robot row.
- Busy  out  1  high while a move is in progress.
- Done  out  1  one-cycle pulse when a move ends (reached or blocked).
- Blocked  out  1  level; last request was rejected or blocked.
- Collected  out  3  per-trash collected flags (bit i = trash i).

Behaviour:
- Reset (Reset=0, asynchronous) forces: RobotCol=START_COL, RobotRow=START_ROW, Busy=0, Done=0, Blocked=0, Collected=0, frame counter=0, state=IDLE, sync flops=0.
- Frame tick: v_sync passes through two synchronizer flops. Tick = one-cycle pulse on the synchronized rising edge, 2-3 cycles after the v_sync edge.
- FSM states: IDLE, PACE, STEP, FINISH.
- IDLE, on Go=1, checks the target in this order:
  - Target illegal (col 0 or >NUM_COLS, row 0 or >NUM_ROWS), or target equals the obstacle cell: Blocked=1, Done pulse, stay IDLE.
  - Target equals the current cell: Blocked=0, Done pulse next cycle, no movement.
  - Otherwise: latch the target, Blocked=0, counter=0, Busy=1, go to PACE.
- Go while Busy is ignored; the latched target does not change mid-move.
- PACE: counter increments on each tick. On the tick where counter==FRAMES_PER_STEP-1, clear the counter and go to STEP. The first step therefore occurs exactly FRAMES_PER_STEP ticks after acceptance.
- STEP (single cycle):
  - Candidate cell: if column differs from target, move column ±1 toward target; else move row ±1. Columns are corrected before rows.
  - Candidate equals obstacle: position unchanged, Blocked=1, go to FINISH.
  - Otherwise update position. For each i, if the candidate matches trash i, set Collected[i]; flags are sticky.
  - Candidate equals target: go to FINISH; else return to PACE.
- No wrap-around: the robot never leaves 1..NUM_COLS / 1..NUM_ROWS.
- FINISH: Done=1 for one cycle, Busy=0, go to IDLE.
- ClearTrash=1 clears Collected in any state. It takes priority over a same-cycle collection.
- Obstacle and trash inputs are evaluated live at STEP time.
- Reset asserted mid-move aborts immediately to reset values.

Optional Feature:
- Macro: ROBOT_DIAG_MOVE_EN.
- Defined: STEP moves column and row together when both differ (diagonal step). If the diagonal cell is the obstacle, fall back to a column-only step, then a row-only step. Block only if all of these candidates are the obstacle.
- Undefined: column-first, then row, one axis per step as above.

Test Plan:
- Reset, then Go to (4,5) with obstacle at (10,1), FRAMES_PER_STEP=4 -> steps (2,5),(3,5),(4,5), each 4 ticks apart. Done pulses once, Busy=0, Blocked=0.
- Robot at (1,5), Go to (1,2) -> row steps 4,3,2. Done after 12 ticks. Collected[2] set on passing (1,2) when trash2=(1,2).
- Obstacle at (3,5), Go to (6,5) from (1,5) -> robot stops at (2,5), Blocked=1, Done pulse. Next valid Go clears Blocked.
- Go to (11,3), to (0,1), and to the obstacle cell -> immediate Blocked=1 and Done, position unchanged, Busy never asserts.
- Go to the current cell -> Done one cycle after Go, Busy stays 0. A Go pulse during an active move is ignored; the original target is reached.
- Reset asserted at the second step of a move -> RobotCol=1, RobotRow=5, Collected=0, Busy=0 asynchronously. ClearTrash on the same cycle as a landing -> flag stays 0.

Source files
------------

// File: rtl/robot_path_scheduler.sv
// Purpose: frame-paced autonomous mover for the robot sprite on the board grid; steps toward a target, avoids the obstacle, collects trash.
// Latency: first step lands FRAMES_PER_STEP frame ticks after Go is accepted; Done pulses the cycle after the final step or a rejection.
// Backpressure: Go is sampled only while idle; requests during a move are dropped. Define ROBOT_DIAG_MOVE_EN for diagonal stepping.
module robot_path_scheduler #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int NUM_COLS        = 10,
    parameter int NUM_ROWS        = 5,
    parameter int START_COL       = 1,
    parameter int START_ROW       = 5
) (
    input  logic        Clock50,
    input  logic        Reset,
    input  logic        v_sync,
    input  logic        Go,
    input  logic [3:0]  TargetCol,
    input  logic [2:0]  TargetRow,
    input  logic [3:0]  ObstCol,
    input  logic [2:0]  ObstRow,
    input  logic [11:0] TrashCols,
    input  logic [8:0]  TrashRows,
    input  logic        ClearTrash,
    output logic [3:0]  RobotCol,
    output logic [2:0]  RobotRow,
    output logic        Busy,
    output logic        Done,
    output logic        Blocked,
    output logic [2:0]  Collected
);

    localparam logic [3:0] LP_MAX_COL   = 4'(NUM_COLS);
    localparam logic [2:0] LP_MAX_ROW   = 3'(NUM_ROWS);
    localparam logic [3:0] LP_START_COL = 4'(START_COL);
    localparam logic [2:0] LP_START_ROW = 3'(START_ROW);
    localparam logic [5:0] LP_LAST_CNT  = 6'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PACE   = 2'd1,
        S_STEP   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_vs_meta;
    logic        r_vs_sync;
    logic        r_vs_prev;
    logic        w_tick;

    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;

    logic [3:0]  r_col;
    logic [2:0]  r_row;
    logic [3:0]  r_tgt_col;
    logic [2:0]  r_tgt_row;
    logic        r_done;
    logic        r_blocked;
    logic [2:0]  r_collected;

    logic        w_done_nxt;
    logic        w_blocked_nxt;
    logic        w_latch;
    logic        w_move;

    logic        w_tgt_illegal;
    logic        w_tgt_obst;
    logic        w_tgt_here;

    logic        w_col_ne;
    logic        w_row_ne;
    logic [3:0]  w_col_step;
    logic [2:0]  w_row_step;
    logic        w_hit_colonly;
    logic        w_hit_rowonly;
`ifdef ROBOT_DIAG_MOVE_EN
    logic        w_hit_diag;
`endif

    logic [3:0]  w_cand_col;
    logic [2:0]  w_cand_row;
    logic        w_cand_hit;
    logic        w_cand_at_tgt;
    logic [2:0]  w_trash_hit;

    // v_sync is asynchronous: two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= v_sync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_tick = r_vs_sync & ~r_vs_prev;

    // Request screening uses live target and obstacle inputs while idle
    assign w_tgt_illegal = (TargetCol == 4'd0) || (TargetCol > LP_MAX_COL) ||
                           (TargetRow == 3'd0) || (TargetRow > LP_MAX_ROW);
    assign w_tgt_obst    = (TargetCol == ObstCol) && (TargetRow == ObstRow);
    assign w_tgt_here    = (TargetCol == r_col) && (TargetRow == r_row);

    // One-cell moves toward the latched target on each axis; the target is always
    // legal, so these never leave the board
    assign w_col_ne   = (r_col != r_tgt_col);
    assign w_row_ne   = (r_row != r_tgt_row);
    assign w_col_step = (r_tgt_col > r_col) ? (r_col + 4'd1) : (r_col - 4'd1);
    assign w_row_step = (r_tgt_row > r_row) ? (r_row + 3'd1) : (r_row - 3'd1);

    assign w_hit_colonly = (w_col_step == ObstCol) && (r_row == ObstRow);
    assign w_hit_rowonly = (r_col == ObstCol) && (w_row_step == ObstRow);
`ifdef ROBOT_DIAG_MOVE_EN
    assign w_hit_diag    = (w_col_step == ObstCol) && (w_row_step == ObstRow);
`endif

    // Choose the candidate cell for this step; w_cand_hit means every allowed candidate is the obstacle
    always_comb begin
        w_cand_col = r_col;
        w_cand_row = r_row;
        w_cand_hit = 1'b0;
`ifdef ROBOT_DIAG_MOVE_EN
        if (w_col_ne && w_row_ne) begin
            if (!w_hit_diag) begin
                w_cand_col = w_col_step;
                w_cand_row = w_row_step;
            end else if (!w_hit_colonly) begin
                w_cand_col = w_col_step;
            end else if (!w_hit_rowonly) begin
                w_cand_row = w_row_step;
            end else begin
                w_cand_hit = 1'b1;
            end
        end else if (w_col_ne) begin
            w_cand_col = w_col_step;
            w_cand_hit = w_hit_colonly;
        end else begin
            w_cand_row = w_row_step;
            w_cand_hit = w_hit_rowonly;
        end
`else
        if (w_col_ne) begin
            w_cand_col = w_col_step;
            w_cand_hit = w_hit_colonly;
        end else begin
            w_cand_row = w_row_step;
            w_cand_hit = w_hit_rowonly;
        end
`endif
    end

    assign w_cand_at_tgt = (w_cand_col == r_tgt_col) && (w_cand_row == r_tgt_row);

    // Which trash sprites sit on the candidate cell (live inputs)
    always_comb begin
        w_trash_hit = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_trash_hit[i] = (TrashCols[i*4 +: 4] == w_cand_col) &&
                             (TrashRows[i*3 +: 3] == w_cand_row);
        end
    end

    // FSM state register
    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus datapath controls
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_blocked_nxt = r_blocked;
        w_latch       = 1'b0;
        w_move        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Go) begin
                    if (w_tgt_illegal || w_tgt_obst) begin
                        w_blocked_nxt = 1'b1;
                        w_done_nxt    = 1'b1;
                    end else if (w_tgt_here) begin
                        w_blocked_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_blocked_nxt = 1'b0;
                        w_cnt_nxt     = 6'd0;
                        w_latch       = 1'b1;
                        w_state_nxt   = S_PACE;
                    end
                end
            end
            S_PACE: begin
                if (w_tick) begin
                    if (r_cnt == LP_LAST_CNT) begin
                        w_cnt_nxt   = 6'd0;
                        w_state_nxt = S_STEP;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            S_STEP: begin
                if (w_cand_hit) begin
                    w_blocked_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_FINISH;
                end else begin
                    w_move = 1'b1;
                    if (w_cand_at_tgt) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_PACE;
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Position, target latch, pacing counter and status flags
    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            r_col     <= LP_START_COL;
            r_row     <= LP_START_ROW;
            r_tgt_col <= LP_START_COL;
            r_tgt_row <= LP_START_ROW;
            r_cnt     <= 6'd0;
            r_done    <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_blocked <= w_blocked_nxt;
            if (w_latch) begin
                r_tgt_col <= TargetCol;
                r_tgt_row <= TargetRow;
            end
            if (w_move) begin
                r_col <= w_cand_col;
                r_row <= w_cand_row;
            end
        end
    end

    // Sticky collected flags; a clear wins over a collection in the same cycle
    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            r_collected <= 3'b000;
        end else if (ClearTrash) begin
            r_collected <= 3'b000;
        end else if (w_move) begin
            r_collected <= r_collected | w_trash_hit;
        end
    end

    assign RobotCol  = r_col;
    assign RobotRow  = r_row;
    assign Busy      = (r_state == S_PACE) || (r_state == S_STEP);
    assign Done      = r_done;
    assign Blocked   = r_blocked;
    assign Collected = r_collected;

endmodule

// File: tb/tb_robot_path_scheduler.sv
// Purpose: self-checking bench for robot_path_scheduler: request screening table, directed moves, corner sequences, random moves.
// Latency: one frame = 12 clocks; frame ticks land 2-3 clocks after each v_sync rise.
// Backpressure: none; Go is pulsed for a single cycle.
`timescale 1ns/1ps
module tb_robot_path_scheduler;

    localparam int F = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        v_sync = 1'b0;
    logic        go = 1'b0;
    logic [3:0]  tcol = 4'd0;
    logic [2:0]  trow = 3'd0;
    logic [3:0]  ocol = 4'd10;
    logic [2:0]  orow = 3'd1;
    logic [11:0] tr_cols = 12'd0;
    logic [8:0]  tr_rows = 9'd0;
    logic        clr = 1'b0;

    logic [3:0]  RobotCol;
    logic [2:0]  RobotRow;
    logic        Busy;
    logic        Done;
    logic        Blocked;
    logic [2:0]  Collected;

    robot_path_scheduler #(
        .FRAMES_PER_STEP (F),
        .NUM_COLS        (10),
        .NUM_ROWS        (5),
        .START_COL       (1),
        .START_ROW       (5)
    ) dut (
        .Clock50    (clk),
        .Reset      (rst_n),
        .v_sync     (v_sync),
        .Go         (go),
        .TargetCol  (tcol),
        .TargetRow  (trow),
        .ObstCol    (ocol),
        .ObstRow    (orow),
        .TrashCols  (tr_cols),
        .TrashRows  (tr_rows),
        .ClearTrash (clr),
        .RobotCol   (RobotCol),
        .RobotRow   (RobotRow),
        .Busy       (Busy),
        .Done       (Done),
        .Blocked    (Blocked),
        .Collected  (Collected)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    // Count Done and Busy cycles on the falling edge
    always @(negedge clk) begin
        if (Done) done_cnt++;
        if (Busy) busy_cnt++;
    end

    // Reference model state
    int         m_col;
    int         m_row;
    bit         m_blk;
    logic [2:0] m_coll;

    typedef struct {
        int tc;
        int tr;
        int oc;
        int orr;
        bit exp_blk;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, " col"}, 32'(RobotCol), 32'(m_col));
        check({tag, " row"}, 32'(RobotRow), 32'(m_row));
        check({tag, " collected"}, 32'(Collected), 32'(m_coll));
    endtask

    function automatic bit legal(input int c, input int r);
        return (c >= 1) && (c <= 10) && (r >= 1) && (r <= 5);
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic bit is_obst(input int c, input int r);
        return (c == int'(ocol)) && (r == int'(orow));
    endfunction

    // Next cell toward (tc,tr); returns 0 when every permitted candidate is the obstacle
    function automatic bit model_step(input int c, input int r, input int tc, input int tr,
                                      output int nc, output int nr);
        int dc;
        int dr;
        dc = sgn(tc - c);
        dr = sgn(tr - r);
        nc = c;
        nr = r;
`ifdef ROBOT_DIAG_MOVE_EN
        if (dc != 0 && dr != 0 && !is_obst(c + dc, r + dr)) begin
            nc = c + dc;
            nr = r + dr;
            return 1'b1;
        end
        if (dc != 0 && !is_obst(c + dc, r)) begin
            nc = c + dc;
            return 1'b1;
        end
        if (dr != 0 && !is_obst(c, r + dr)) begin
            nr = r + dr;
            return 1'b1;
        end
        return 1'b0;
`else
        if (dc != 0) begin
            if (is_obst(c + dc, r)) return 1'b0;
            nc = c + dc;
            return 1'b1;
        end
        if (is_obst(c, r + dr)) return 1'b0;
        nr = r + dr;
        return 1'b1;
`endif
    endfunction

    task automatic model_land(input int c, input int r);
        m_col = c;
        m_row = r;
        for (int i = 0; i < 3; i++) begin
            if (int'(tr_cols[i*4 +: 4]) == c && int'(tr_rows[i*3 +: 3]) == r) m_coll[i] = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_col  = 1;
        m_row  = 5;
        m_blk  = 1'b0;
        m_coll = 3'b000;
    endtask

    // All tasks enter and leave 2 ns after a rising edge
    task automatic pulse_go(input int c, input int r);
        tcol = 4'(c);
        trow = 3'(r);
        go   = 1'b1;
        @(posedge clk);
        #2;
        go   = 1'b0;
    endtask

    task automatic clear_trash();
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
        m_coll = 3'b000;
    endtask

    // One video frame. act=1 raises ClearTrash exactly for the STEP cycle that a
    // terminal-count tick in this frame produces; act=2 drops reset in that cycle and returns.
    task automatic frame(input int act);
        v_sync = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        if (act == 1) clr = 1'b1;
        if (act == 2) begin
            rst_n = 1'b0;
            return;
        end
        @(posedge clk);
        #2;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        v_sync = 1'b0;
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic run_move(input int tc, input int tr, input bit inject);
        int d0;
        int b0;
        int nc;
        int nr;
        bit moved;
        bit fin;
        bit bad;
        bit here;
        d0   = done_cnt;
        b0   = busy_cnt;
        bad  = !legal(tc, tr) || is_obst(tc, tr);
        here = (tc == m_col) && (tr == m_row);
        pulse_go(tc, tr);
        if (bad || here) begin
            m_blk = bad;
            check("imm done pulse", 32'(Done), 32'd1);
            repeat (3) @(posedge clk);
            #2;
            check("imm done count", 32'(done_cnt - d0), 32'd1);
            check("imm busy cycles", 32'(busy_cnt - b0), 32'd0);
            check("imm blocked", 32'(Blocked), 32'(m_blk));
            check_pos("imm");
            return;
        end
        m_blk = 1'b0;
        check("accept busy", 32'(Busy), 32'd1);
        check("accept blocked", 32'(Blocked), 32'd0);
        fin = 1'b0;
        for (int s = 0; s < 20 && !fin; s++) begin
            moved = model_step(m_col, m_row, tc, tr, nc, nr);
            for (int f = 1; f <= F; f++) begin
                frame(0);
                if (inject && s == 0 && f == 1) pulse_go(9, 1);
                if (f < F) begin
                    check("pace busy", 32'(Busy), 32'd1);
                    check_pos("pace");
                end
            end
            if (!moved) begin
                m_blk = 1'b1;
                fin   = 1'b1;
            end else begin
                model_land(nc, nr);
                if (nc == tc && nr == tr) fin = 1'b1;
            end
            check_pos("step");
            if (!fin) check("step busy", 32'(Busy), 32'd1);
        end
        check("end done count", 32'(done_cnt - d0), 32'd1);
        check("end busy", 32'(Busy), 32'd0);
        check("end blocked", 32'(Blocked), 32'(m_blk));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        vecs[0] = '{11, 3, 10, 1, 1'b1};
        vecs[1] = '{ 0, 1, 10, 1, 1'b1};
        vecs[2] = '{ 4, 0, 10, 1, 1'b1};
        vecs[3] = '{ 2, 6, 10, 1, 1'b1};
        vecs[4] = '{10, 1, 10, 1, 1'b1};
        vecs[5] = '{ 1, 5, 10, 1, 1'b0};
        vecs[6] = '{ 3, 2,  3, 2, 1'b1};

        #5;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        model_reset();
        check("reset col", 32'(RobotCol), 32'd1);
        check("reset row", 32'(RobotRow), 32'd5);
        check("reset busy", 32'(Busy), 32'd0);
        check("reset done", 32'(Done), 32'd0);
        check("reset blocked", 32'(Blocked), 32'd0);
        check("reset collected", 32'(Collected), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Requests that resolve immediately, applied from the start cell
        for (int k = 0; k < 7; k++) begin
            int b0;
            ocol = 4'(vecs[k].oc);
            orow = 3'(vecs[k].orr);
            d0 = done_cnt;
            b0 = busy_cnt;
            pulse_go(vecs[k].tc, vecs[k].tr);
            check("vec done next cycle", 32'(Done), 32'd1);
            repeat (3) @(posedge clk);
            #2;
            check("vec done count", 32'(done_cnt - d0), 32'd1);
            check("vec busy cycles", 32'(busy_cnt - b0), 32'd0);
            check("vec blocked", 32'(Blocked), 32'(vecs[k].exp_blk));
            check("vec col", 32'(RobotCol), 32'd1);
            check("vec row", 32'(RobotRow), 32'd5);
        end
        m_blk = 1'b1;

        // Column move, then a move back with a stray Go mid-move
        ocol = 4'd10;
        orow = 3'd1;
        run_move(4, 5, 1'b0);
        check("move1 col", 32'(RobotCol), 32'd4);
        run_move(1, 5, 1'b1);
        check("inject col", 32'(RobotCol), 32'd1);

        // Row move collecting trash2 at the target
        tr_cols[11:8] = 4'd1;
        tr_rows[8:6]  = 3'd2;
        run_move(1, 2, 1'b0);
        check("trash2 collected", 32'(Collected), 32'd4);

        // Blocked by obstacle, then a valid move clears Blocked
        run_move(1, 5, 1'b0);
        ocol = 4'd3;
        orow = 3'd5;
        run_move(6, 5, 1'b0);
        check("blocked col", 32'(RobotCol), 32'd2);
        check("blocked flag", 32'(Blocked), 32'd1);
        ocol = 4'd10;
        orow = 3'd1;
        run_move(2, 4, 1'b0);
        check("unblocked flag", 32'(Blocked), 32'd0);
        run_move(2, 4, 1'b0);

        // ClearTrash in the landing cycle wins over collection
        clear_trash();
        tr_cols[3:0] = 4'd3;
        tr_rows[2:0] = 3'd4;
        d0 = done_cnt;
        pulse_go(3, 4);
        repeat (F - 1) frame(0);
        frame(1);
        check("clr landing col", 32'(RobotCol), 32'd3);
        check("clr landing collected", 32'(Collected), 32'd0);
        check("clr landing done", 32'(done_cnt - d0), 32'd1);
        m_col = 3;
        m_row = 4;
        run_move(4, 4, 1'b0);
        run_move(3, 4, 1'b0);
        check("trash0 collected", 32'(Collected[0]), 32'd1);

        // Reset asserted in the second step cycle of a move
        clear_trash();
        tr_cols[7:4] = 4'd4;
        tr_rows[5:3] = 3'd4;
        pulse_go(6, 4);
        repeat (F) frame(0);
        check("pre-reset col", 32'(RobotCol), 32'd4);
        check("pre-reset collected", 32'(Collected), 32'd2);
        repeat (F - 1) frame(0);
        frame(2);
        #1;
        check("async reset col", 32'(RobotCol), 32'd1);
        check("async reset row", 32'(RobotRow), 32'd5);
        check("async reset busy", 32'(Busy), 32'd0);
        check("async reset collected", 32'(Collected), 32'd0);
        check("async reset done", 32'(Done), 32'd0);
        v_sync = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_pos("post reset");
        check("post reset busy", 32'(Busy), 32'd0);

        // Random moves against the model
        for (int k = 0; k < 30; k++) begin
            int oc;
            int orr;
            do begin
                oc  = int'($urandom_range(1, 10));
                orr = int'($urandom_range(1, 5));
            end while (oc == m_col && orr == m_row);
            ocol = 4'(oc);
            orow = 3'(orr);
            for (int i = 0; i < 3; i++) begin
                tr_cols[i*4 +: 4] = 4'($urandom_range(1, 10));
                tr_rows[i*3 +: 3] = 3'($urandom_range(1, 5));
            end
            if ($urandom_range(0, 5) == 0) clear_trash();
            run_move(int'($urandom_range(0, 11)), int'($urandom_range(0, 6)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
